// File: rtl/ramcpy_pkg.sv
// Shared types and default widths for the RAM512 block copier.
package ramcpy_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [DEFAULT_ADDR_W:0] len_t;

endpackage

// File: rtl/ram_block_copier_if.sv
// RAM512 word-memory port: the copier is the master, the memory the slave.
interface ram_block_copier_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ld;

    modport master (output mem_addr, output mem_wdata, output mem_ld, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_ld, output mem_rdata);
endinterface

// File: rtl/ramcpy_addr_gen.sv
// Source/destination cursors and remaining-word counter for the block copier.
module ramcpy_addr_gen #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [ADDR_W:0]   len_i,
    output logic [ADDR_W-1:0] src_nxt_o,
    output logic [ADDR_W-1:0] dst_cur_o,
    output logic [ADDR_W-1:0] dst_nxt_o,
    output logic              zero_nxt_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // Address increments drop the carry, so cursors wrap modulo the memory depth.
    assign src_nxt_o  = src_q + ADDR_ONE;
    assign dst_nxt_o  = dst_q + ADDR_ONE;
    assign dst_cur_o  = dst_q;
    assign zero_nxt_o = (cnt_q == LEN_ONE);

    // Next-state selection: load on accepted start, advance after each write.
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        if (load_i) begin
            src_d = src_i;
            dst_d = dst_i;
            cnt_d = len_i;
        end else if (step_i) begin
            src_d = src_nxt_o;
            dst_d = dst_nxt_o;
            cnt_d = cnt_q - LEN_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Cursor and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= {ADDR_W{1'b0}};
            dst_q <= {ADDR_W{1'b0}};
            cnt_q <= {(ADDR_W+1){1'b0}};
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_block_copier.sv
// Copies len words from src_addr to dst_addr inside one RAM512 (read cycle, then write cycle).
// Optional RAMCPY_FILL_EN adds a fill mode writing fill_data once per cycle, skipping reads.
module ram_block_copier
    import ramcpy_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
`ifdef RAMCPY_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    ram_block_copier_if.master mem
);

    state_t            state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] buf_q;
    logic              mem_ld_q;
    logic              busy_q;
    logic              done_q;
    logic              fill_q;

    logic              load_s;
    logic              step_s;
    logic              fill_req_s;
    logic [DATA_W-1:0] fill_val_s;
    logic [ADDR_W-1:0] src_nxt_s;
    logic [ADDR_W-1:0] dst_cur_s;
    logic [ADDR_W-1:0] dst_nxt_s;
    logic              zero_nxt_s;

`ifdef RAMCPY_FILL_EN
    assign fill_req_s = fill;
    assign fill_val_s = fill_data;
`else
    assign fill_req_s = 1'b0;
    assign fill_val_s = {DATA_W{1'b0}};
`endif

    // Cursor control: load on an accepted start, step once per completed write.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        if (state_q == IDLE) begin
            load_s = start;
        end else if (state_q == WRITE) begin
            step_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    ramcpy_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_s),
        .step_i     (step_s),
        .src_i      (src_addr),
        .dst_i      (dst_addr),
        .len_i      (len),
        .src_nxt_o  (src_nxt_s),
        .dst_cur_o  (dst_cur_s),
        .dst_nxt_o  (dst_nxt_s),
        .zero_nxt_o (zero_nxt_s)
    );

    // Transfer FSM; every output is registered and set up for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= {ADDR_W{1'b0}};
            buf_q      <= {DATA_W{1'b0}};
            mem_ld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fill_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_ld_q   <= 1'b0;
                    mem_addr_q <= {ADDR_W{1'b0}};
                    done_q     <= 1'b0;
                    if (start) begin
                        fill_q <= fill_req_s;
                        if (fill_req_s) begin
                            buf_q <= fill_val_s;
                        end
                        if (len == {(ADDR_W+1){1'b0}}) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (fill_req_s) begin
                            state_q    <= WRITE;
                            busy_q     <= 1'b1;
                            mem_ld_q   <= 1'b1;
                            mem_addr_q <= dst_addr;
                        end else begin
                            state_q    <= READ;
                            busy_q     <= 1'b1;
                            mem_addr_q <= src_addr;
                        end
                    end
                end
                READ: begin
                    buf_q      <= mem.mem_rdata;
                    mem_addr_q <= dst_cur_s;
                    mem_ld_q   <= 1'b1;
                    state_q    <= WRITE;
                end
                WRITE: begin
                    if (zero_nxt_s) begin
                        state_q    <= DONE;
                        mem_ld_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        mem_addr_q <= {ADDR_W{1'b0}};
                    end else if (fill_q) begin
                        mem_addr_q <= dst_nxt_s;
                    end else begin
                        state_q    <= READ;
                        mem_ld_q   <= 1'b0;
                        mem_addr_q <= src_nxt_s;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    mem_ld_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    mem_addr_q <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = buf_q;
    assign mem.mem_ld    = mem_ld_q;

endmodule

// File: tb/tb_ram_block_copier.sv
// Directed, table-driven bench for ram_block_copier with a behavioural RAM512 model.
module tb_ram_block_copier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  src_addr = 9'd0;
    logic [8:0]  dst_addr = 9'd0;
    logic [9:0]  len = 10'd0;
    logic        fill = 1'b0;
    logic [15:0] fill_data = 16'h0000;
    logic        busy;
    logic        done;

    logic        pre_we = 1'b0;
    logic [8:0]  pre_addr = 9'd0;
    logic [15:0] pre_data = 16'h0000;
    logic [15:0] ram [512];

    int n_checks = 0;
    int n_fail = 0;

    ram_block_copier_if #(.DATA_W(16), .ADDR_W(9)) mem_if ();

    ram_block_copier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
`ifdef RAMCPY_FILL_EN
        .fill      (fill),
        .fill_data (fill_data),
`endif
        .busy      (busy),
        .done      (done),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    assign mem_if.mem_rdata = ram[mem_if.mem_addr];

    always @(posedge clk) begin
        if (mem_if.mem_ld) ram[mem_if.mem_addr] <= mem_if.mem_wdata;
        else if (pre_we)   ram[pre_addr] <= pre_data;
    end

    typedef struct {
        logic [8:0]       src;
        logic [8:0]       dst;
        logic [9:0]       len;
        int               exp_done;
        bit               start_at_done;
        logic [8:0]       pre_a;
        int               pre_n;
        logic [3:0][15:0] pre_v;
        logic [8:0]       chk_a;
        int               chk_n;
        logic [3:0][15:0] chk_v;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pre(input logic [8:0] a, input logic [15:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Launch one transfer and observe it until three cycles after done (or a budget expires).
    task automatic run_xfer(input logic [8:0] s, input logic [8:0] d, input logic [9:0] l,
                            input bit f, input logic [15:0] fd, input int restart_cyc,
                            input bit start_at_done, output int done_cyc, output int nwr,
                            output int ld_bad, output int done_cnt, output int busy_after);
        bit prev_ld;
        int exp_c;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; fill = f; fill_data = fd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = -1; nwr = 0; ld_bad = 0; done_cnt = 0; busy_after = 0; prev_ld = 1'b0;
        for (int c = 1; c < 2000; c++) begin
            if (mem_if.mem_ld) begin
                exp_c = f ? nwr + 1 : 2 * nwr + 2;
                if (c != exp_c) ld_bad++;
                if (prev_ld && !f) ld_bad++;
                nwr++;
            end
            prev_ld = mem_if.mem_ld;
            if (done_cyc >= 0 && busy) busy_after++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (start_at_done) start = 1'b1;
            end
            if (c == restart_cyc) begin
                src_addr = s + 9'd50;
                start = 1'b1;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (done_cyc < 0) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: no done pulse within budget");
        end
    endtask

    initial begin
        int dc, nw, lb, dn, ba, errs;
        logic [8:0] a;

        vecs[0] = '{9'd10, 9'd100, 10'd4, 9, 1'b0, 9'd10, 4, {16'hA004, 16'hA003, 16'hA002, 16'hA001},
                    9'd100, 4, {16'hA004, 16'hA003, 16'hA002, 16'hA001}};
        vecs[1] = '{9'd5, 9'd6, 10'd0, 1, 1'b1, 9'd5, 2, {16'h0000, 16'h0000, 16'h6666, 16'h5555},
                    9'd5, 2, {16'h0000, 16'h0000, 16'h6666, 16'h5555}};
        vecs[2] = '{9'd510, 9'd0, 10'd3, 7, 1'b0, 9'd510, 3, {16'h0000, 16'h3333, 16'h2222, 16'h1111},
                    9'd0, 3, {16'h0000, 16'h1111, 16'h2222, 16'h1111}};
        vecs[3] = '{9'd300, 9'd302, 10'd4, 9, 1'b1, 9'd300, 4, {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                    9'd302, 4, {16'h0002, 16'h0001, 16'h0002, 16'h0001}};
        vecs[4] = '{9'd0, 9'd511, 10'd2, 5, 1'b0, 9'd0, 2, {16'h0000, 16'h0000, 16'hF00D, 16'hCAFE},
                    9'd511, 2, {16'h0000, 16'h0000, 16'hF00D, 16'hCAFE}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ld", {31'd0, mem_if.mem_ld}, 32'd0);
        chk("rst_addr", {23'd0, mem_if.mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_if.mem_wdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of copy transfers
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].pre_n; k++) begin
                a = vecs[i].pre_a + 9'(k);
                pre(a, vecs[i].pre_v[k]);
            end
            run_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, 1'b0, 16'h0000, 0,
                     vecs[i].start_at_done, dc, nw, lb, dn, ba);
            chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
            chk($sformatf("v%0d_writes", i), nw, {22'd0, vecs[i].len});
            chk($sformatf("v%0d_ld_timing", i), lb, 32'd0);
            chk($sformatf("v%0d_done_pulses", i), dn, 32'd1);
            chk($sformatf("v%0d_busy_after", i), ba, 32'd0);
            for (int k = 0; k < vecs[i].chk_n; k++) begin
                a = vecs[i].chk_a + 9'(k);
                chk($sformatf("v%0d_mem[%0d]", i, a), {16'd0, ram[a]}, {16'd0, vecs[i].chk_v[k]});
            end
        end
        chk("src_kept_10", {16'd0, ram[10]}, 32'h0000A001);
        chk("src_kept_13", {16'd0, ram[13]}, 32'h0000A004);

        // start re-pulsed in cycle 3 must be ignored
        run_xfer(9'd10, 9'd120, 10'd4, 1'b0, 16'h0000, 3, 1'b0, dc, nw, lb, dn, ba);
        chk("restart_writes", nw, 32'd4);
        chk("restart_done_pulses", dn, 32'd1);
        chk("restart_done_cycle", dc, 32'd9);
        chk("restart_mem123", {16'd0, ram[123]}, 32'h0000A004);

        // Reset in cycle 3 aborts the transfer after word 0
        pre(9'd40, 16'h4040); pre(9'd41, 16'h4141);
        pre(9'd140, 16'h0000); pre(9'd141, 16'h0000);
        @(negedge clk);
        src_addr = 9'd40; dst_addr = 9'd140; len = 10'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("abort_ld_c2", {31'd0, mem_if.mem_ld}, 32'd1);
        @(posedge clk); #1;
        chk("abort_busy_c3", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ld", {31'd0, mem_if.mem_ld}, 32'd0);
        chk("abort_addr", {23'd0, mem_if.mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_mem140", {16'd0, ram[140]}, 32'h00004040);
        chk("abort_mem141", {16'd0, ram[141]}, 32'h00000000);
        run_xfer(9'd40, 9'd150, 10'd2, 1'b0, 16'h0000, 0, 1'b0, dc, nw, lb, dn, ba);
        chk("after_rst_done_cycle", dc, 32'd5);
        chk("after_rst_mem151", {16'd0, ram[151]}, 32'h00004141);

        // Full-memory copy (len=512)
        for (int k = 0; k < 512; k++) pre(9'(k), 16'(k) ^ 16'h5A5A);
        run_xfer(9'd0, 9'd0, 10'd512, 1'b0, 16'h0000, 0, 1'b0, dc, nw, lb, dn, ba);
        chk("full_done_cycle", dc, 32'd1025);
        chk("full_writes", nw, 32'd512);
        chk("full_ld_timing", lb, 32'd0);
        errs = 0;
        for (int k = 0; k < 512; k++) if (ram[k] !== (16'(k) ^ 16'h5A5A)) errs++;
        chk("full_mem_errors", errs, 32'd0);

`ifdef RAMCPY_FILL_EN
        run_xfer(9'd7, 9'd200, 10'd3, 1'b1, 16'hBEEF, 0, 1'b0, dc, nw, lb, dn, ba);
        chk("fill_done_cycle", dc, 32'd4);
        chk("fill_writes", nw, 32'd3);
        chk("fill_ld_timing", lb, 32'd0);
        for (int k = 200; k < 203; k++) chk($sformatf("fill_mem[%0d]", k), {16'd0, ram[k]}, 32'h0000BEEF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_block_copier.md
Name: ram_block_copier

Overview:
- Memory-side initiator for the RAM512 word-memory interface: drives address, write data and load, and samples the combinational read-data output.
- Copies a block of len words from src_addr to dst_addr inside one RAM512 instance, one word per two cycles (read cycle, then write cycle).
- Sits between control logic (CPU/boot loader) and the RAM512 port; start/busy/done handshake on the control side.

Parameters:
- DATA_W, 16, word width of mem_rdata/mem_wdata.
- ADDR_W, 9, address width; memory depth = 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- src_addr  input  ADDR_W  first source word address, captured on accepted start.
- dst_addr  input  ADDR_W  first destination word address, captured on accepted start.
- len  input  ADDR_W+1  word count 0..512, captured on accepted start.
- busy  output  1  high in READ and WRITE states.
- done  output  1  one-cycle pulse when the transfer completes.
- mem_addr  output  ADDR_W  address to RAM512.
- mem_wdata  output  DATA_W  write data to RAM512.
- mem_ld  output  1  RAM512 load enable; high only in WRITE.
- mem_rdata  input  DATA_W  RAM512 read data (combinational from mem_addr).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, mem_ld=0, mem_addr=0, mem_wdata=0; internal src/dst/count/buffer regs = 0. Reset mid-transfer aborts immediately, mem_ld drops asynchronously, no done pulse, no later writes.
- States: IDLE, READ, WRITE, DONE.
- IDLE: mem_ld=0, mem_addr=0. start=1 at an edge: capture src, dst, len. len!=0 -> READ; len==0 -> DONE (no memory access).
- READ: mem_addr=src_cur, mem_ld=0. At edge: buf <= mem_rdata -> WRITE.
- WRITE: mem_addr=dst_cur, mem_wdata=buf, mem_ld=1. At edge: src_cur+1, dst_cur+1, count-1. Count becomes 0 -> DONE, else -> READ.
- DONE: done=1, busy=0, mem_ld=0. Lasts exactly one cycle -> IDLE.
- Outside WRITE, mem_wdata holds buf (0 after reset).
- Latency: start sampled at edge 0. Word i is read in cycle 2i+1 and written in cycle 2i+2. done is high in cycle 2N+1. len=0 -> done in cycle 1.
- Address arithmetic is modulo 2**ADDR_W: 511+1 wraps to 0, for src and dst independently.
- len=512 copies the full memory.
- Copy is always ascending. For overlapping regions with dst>src, source words already overwritten are read as new data. This is defined behaviour; the block does not detect it.
- start while busy or in DONE: ignored, not queued. start in the same cycle as done: ignored.
- mem_ld never high for two consecutive cycles.

Optional Feature:
- Macro RAMCPY_FILL_EN.
- With it: extra input fill (1) and fill_data (DATA_W), both captured on start. If fill=1, the READ state is skipped (IDLE -> WRITE; WRITE -> WRITE while count>0). buf=fill_data, one word per cycle, done in cycle N+1. mem_ld is continuous in this mode. src_addr is ignored.
- Without it: ports absent, copy-only behaviour as above.

Decomposition:
- Package ramcpy_pkg: ADDR_W/DATA_W defaults, state_t enum {IDLE, READ, WRITE, DONE}, len_t typedef (ADDR_W+1 bits).
- One sub-module, ramcpy_addr_gen: holds src_cur/dst_cur/count with load/step inputs, modulo wrap, and a zero flag. The FSM stays in the top.

Test Plan:
- Preload RAM[10..13]=0xA001..0xA004; start src=10 dst=100 len=4 -> RAM[100..103]=0xA001..0xA004, mem_ld pulses in cycles 2,4,6,8, done in cycle 9, RAM[10..13] unchanged.
- len=0, src=5 dst=6 -> done in cycle 1, mem_ld never asserted, memory unchanged.
- Wrap: src=510 dst=0 len=3, RAM[510]=0x1111, RAM[511]=0x2222, RAM[0]=0x3333 -> RAM[0..2]=0x1111,0x2222,0x1111 (overlap: RAM[0] is written before it is read as the third word).
- start pulsed again in cycle 3 of a len=4 transfer -> ignored; exactly 4 writes and one done pulse.
- rst_n low in cycle 3 of a len=4 copy -> mem_ld=0 immediately, busy=0, only dst word 0 written, no done; a new start after release works normally.
- RAMCPY_FILL_EN: fill=1, fill_data=0xBEEF, dst=200, len=3 -> RAM[200..202]=0xBEEF, mem_ld high in cycles 1–3, done in cycle 4.
